mult_div_unit: RTL

- Multicycle HI/LO multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes rs/rt read data; executes MULT, MULTU, DIV, DIVU iteratively; holds results in architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Its busy output drives the pipeline stall for MFHI/MFLO and for back-to-back mult/div.

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide: bit_size+1 cycles start-to-done; a start while busy is dropped (upstream stalls on busy).
// Optional abort input under `define MDU_ABORT_EN cancels a running op, leaving HI/LO untouched.
module mult_div_unit #(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
`ifdef MDU_ABORT_EN
  input  logic                abort,
`endif
  input  logic [bit_size-1:0] src_a,
  input  logic [bit_size-1:0] src_b,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [bit_size-1:0] wdata,
  output logic [bit_size-1:0] hi,
  output logic [bit_size-1:0] lo,
  output logic                busy,
  output logic                done
);

  localparam int N  = bit_size;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic            div_q, neg_q, rem_neg_q, dz_q;
  logic [N-1:0]    a_raw_q, b_mag_q;
  logic [N-1:0]    acc_hi_q, acc_lo_q;
  logic [N-1:0]    hi_q, lo_q;
  logic            done_q;

  logic            abort_w;
  logic            load, iter, commit, mt_hi, mt_lo;
  logic            signed_op, sa, sb;
  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      sum, trial;
  logic [N-1:0]    acc_hi_d, acc_lo_d;
  logic [2*N-1:0]  prod, prod_fix;
  logic [N-1:0]    res_hi, res_lo;

`ifdef MDU_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (abort_w) state_d = IDLE;
               else if (count_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    load   = (state_q == IDLE) && start;
    iter   = (state_q == RUN) && !abort_w;
    commit = (state_q == FIX) && !abort_w;
    mt_hi  = (state_q == IDLE) && hi_we;
    mt_lo  = (state_q == IDLE) && lo_we;
  end

  // Multiply and divide share one load path: low half holds multiplier / dividend magnitude.
  always_comb begin
    signed_op = ~op[0];
    sa        = signed_op & src_a[N-1];
    sb        = signed_op & src_b[N-1];
    mag_a     = sa ? -src_a : src_a;
    mag_b     = sb ? -src_b : src_b;
  end

  always_comb begin
    sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : {(N+1){1'b0}});
    trial    = {acc_hi_q, acc_lo_q[N-1]} - {1'b0, b_mag_q};
    acc_hi_d = sum[N:1];
    acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
    if (div_q) begin
      if (!trial[N]) begin
        acc_hi_d = trial[N-1:0];
        acc_lo_d = {acc_lo_q[N-2:0], 1'b1};
      end else begin
        acc_hi_d = {acc_hi_q[N-2:0], acc_lo_q[N-1]};
        acc_lo_d = {acc_lo_q[N-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*N-1:N];
    res_lo   = prod_fix[N-1:0];
    if (div_q) begin
      if (dz_q) begin
        res_hi = a_raw_q;
        res_lo = {N{1'b1}};
      end else begin
        res_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
        res_lo = neg_q ? -acc_lo_q : acc_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
    end else if (load) begin
      count_q   <= '0;
      div_q     <= op[1];
      neg_q     <= sa ^ sb;
      rem_neg_q <= sa;
      dz_q      <= op[1] && (src_b == '0);
      a_raw_q   <= src_a;
      b_mag_q   <= mag_b;
      acc_hi_q  <= '0;
      acc_lo_q  <= mag_a;
    end else if (iter) begin
      count_q   <= count_q + CW'(1);
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
    end
  end

  // MTHI/MTLO only land in IDLE, so they can never collide with a FIX write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit)     hi_q <= res_hi;
      else if (mt_hi) hi_q <= wdata;
      if (commit)     lo_q <= res_lo;
      else if (mt_lo) lo_q <= wdata;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule
